// File: rtl/cpu_pkg.sv
// Shared core definitions: register file geometry, scoreboard defaults, error causes.
// SCB_BYPASS_EN selects the WB-to-ID same-cycle hazard bypass.
package cpu_pkg;
  localparam int REG_IDX_W         = 5;
  localparam int NUM_REGS          = 32;
  localparam int MAX_INFLIGHT_DFLT = 2;

  typedef enum logic [1:0] {
    ERR_UNDERFLOW    = 2'd0,
    ERR_SPURIOUS_CLR = 2'd1,
    ERR_OVERFLOW     = 2'd2
  } scb_err_e;

  localparam int NUM_ERR = 3;

`ifdef SCB_BYPASS_EN
  localparam bit SCB_BYPASS = 1'b1;
`else
  localparam bit SCB_BYPASS = 1'b0;
`endif
endpackage

// File: rtl/scb_hazard_chk.sv
// Combinational RAW/WAW lookup against the pending-write bitmap.
// Under SCB_BYPASS_EN, registers being retired this cycle are treated as free.
module scb_hazard_chk
  import cpu_pkg::*;
(
  input  logic [NUM_REGS-1:0]  busy,
  input  logic [NUM_REGS-1:0]  clr_mask,
  input  logic                 rs1_ren,
  input  logic                 rs2_ren,
  input  logic                 rd_wen,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  input  logic [REG_IDX_W-1:0] rd,
  output logic                 raw,
  output logic                 waw
);
  logic [NUM_REGS-1:0] eff_busy;

  always_comb begin
    eff_busy    = SCB_BYPASS ? (busy & ~clr_mask) : busy;
    eff_busy[0] = 1'b0;
    raw = (rs1_ren & eff_busy[rs1]) | (rs2_ren & eff_busy[rs2]);
    waw = rd_wen & eff_busy[rd];
  end
endmodule

// File: rtl/scoreboard_ctrl.sv
// Issue controller for the ID->IS->WB pipeline: busy bitmap, in-flight count, hazard stall.
// Build with SCB_BYPASS_EN for same-cycle WB bypass (needs a write-through regfile).
module scoreboard_ctrl
  import cpu_pkg::*;
#(
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DFLT,
  parameter int CNT_W        = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic                 id_rs1_ren,
  input  logic                 id_rs2_ren,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_rd_wen,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 id_serialize,
  input  logic                 is_ready,
  input  logic                 redirect,
  input  logic                 wb_valid,
  input  logic                 wb_rd_wen,
  input  logic [REG_IDX_W-1:0] wb_rd,
  output logic                 id_fire,
  output logic                 id_stall,
  output logic                 id_kill,
  output logic [NUM_REGS-1:0]  busy_map,
  output logic [CNT_W-1:0]     inflight,
  output logic                 scb_err
);
  logic [NUM_REGS-1:0] busy_q, busy_nxt, clr_mask, set_mask;
  logic [CNT_W-1:0]    inflight_q, inflight_nxt;
  logic                err_q;
  logic                raw, waw, full, ser, wb_clr, inflight_zero;
  logic [NUM_ERR-1:0]  err_cause;

  assign wb_clr        = wb_valid & wb_rd_wen & (wb_rd != '0);
  assign inflight_zero = (inflight_q == '0);

  scb_hazard_chk u_hazard (
    .busy     (busy_q),
    .clr_mask (clr_mask),
    .rs1_ren  (id_rs1_ren),
    .rs2_ren  (id_rs2_ren),
    .rd_wen   (id_rd_wen),
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .rd       (id_rd),
    .raw      (raw),
    .waw      (waw)
  );

  // A lone retiring instruction empties the pipe this cycle when bypass is enabled
  assign full = (inflight_q == CNT_W'(MAX_INFLIGHT));
  assign ser  = id_serialize & ~inflight_zero &
                ~(SCB_BYPASS & wb_valid & (inflight_q == CNT_W'(1)));

  assign id_kill  = id_valid & redirect;
  assign id_stall = id_valid & ~redirect & (raw | waw | full | ser | ~is_ready);
  assign id_fire  = id_valid & ~redirect & ~id_stall;

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (wb_clr)
      clr_mask[wb_rd] = 1'b1;
    if (id_fire & id_rd_wen & (id_rd != '0))
      set_mask[id_rd] = 1'b1;
    busy_nxt    = (busy_q & ~clr_mask) | set_mask;
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    inflight_nxt = inflight_q;
    if (id_fire & ~wb_valid)
      inflight_nxt = inflight_q + CNT_W'(1);
    else if (~id_fire & wb_valid & ~inflight_zero)
      inflight_nxt = inflight_q - CNT_W'(1);
  end

  always_comb begin
    err_cause                   = '0;
    err_cause[ERR_UNDERFLOW]    = wb_valid & inflight_zero;
    err_cause[ERR_SPURIOUS_CLR] = wb_clr & ~busy_q[wb_rd];
    err_cause[ERR_OVERFLOW]     = id_fire & full;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q     <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_nxt;
      inflight_q <= inflight_nxt;
      err_q      <= err_q | (|err_cause);
    end
  end

  assign busy_map = busy_q;
  assign inflight = inflight_q;
  assign scb_err  = err_q;
endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Self-checking bench for scoreboard_ctrl: directed scenarios then random traffic vs a reference model.
module tb_scoreboard_ctrl;
  localparam int MAXI = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid, id_rs1_ren, id_rs2_ren, id_rd_wen, id_serialize;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       is_ready, redirect, wb_valid, wb_rd_wen;
  logic [4:0] wb_rd;
  logic       id_fire, id_stall, id_kill, scb_err;
  logic [31:0] busy_map;
  logic [2:0]  inflight;

  always #5 clk = ~clk;

  scoreboard_ctrl #(.MAX_INFLIGHT(MAXI), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1_ren(id_rs1_ren), .id_rs2_ren(id_rs2_ren),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd_wen(id_rd_wen), .id_rd(id_rd),
    .id_serialize(id_serialize), .is_ready(is_ready), .redirect(redirect),
    .wb_valid(wb_valid), .wb_rd_wen(wb_rd_wen), .wb_rd(wb_rd),
    .id_fire(id_fire), .id_stall(id_stall), .id_kill(id_kill),
    .busy_map(busy_map), .inflight(inflight), .scb_err(scb_err)
  );

  // Reference model: set of registers with a pending write, count of issued-not-retired
  bit [31:0] m_busy;
  int        m_inf;
  bit        m_err;
  bit        e_fire, e_stall, e_kill;
  logic      last_fire, last_stall, last_kill;
  int        total = 0;
  int        bad   = 0;

  function automatic bit pending(input logic [4:0] r);
    if (r == 5'd0 || !m_busy[r]) return 1'b0;
`ifdef SCB_BYPASS_EN
    if (wb_valid && wb_rd_wen && wb_rd == r) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic void predict();
    bit hazard;
    int older;
    older = m_inf;
`ifdef SCB_BYPASS_EN
    older = m_inf - int'(wb_valid);
`endif
    hazard = (id_rs1_ren && pending(id_rs1)) || (id_rs2_ren && pending(id_rs2)) ||
             (id_rd_wen && pending(id_rd)) || (m_inf == MAXI) ||
             (id_serialize && older > 0) || !is_ready;
    e_kill  = id_valid && redirect;
    e_stall = id_valid && !redirect && hazard;
    e_fire  = id_valid && !redirect && !hazard;
  endfunction

  function automatic void commit();
    if (wb_valid && m_inf == 0) m_err = 1'b1;
    if (wb_valid && wb_rd_wen && wb_rd != 5'd0 && !m_busy[wb_rd]) m_err = 1'b1;
    if (e_fire && m_inf == MAXI) m_err = 1'b1;
    if (wb_valid && wb_rd_wen && wb_rd != 5'd0) m_busy[wb_rd] = 1'b0;
    if (e_fire && id_rd_wen && id_rd != 5'd0) m_busy[id_rd] = 1'b1;
    m_inf = m_inf + int'(e_fire) - int'(wb_valid);
    if (m_inf < 0) m_inf = 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_busy"}, busy_map, m_busy);
    chk({tag, "_inflight"}, 32'(inflight), 32'(m_inf));
    chk({tag, "_err"}, 32'(scb_err), 32'(m_err));
  endtask

  task automatic cycle();
    @(negedge clk);
    predict();
    last_fire  = id_fire;
    last_stall = id_stall;
    last_kill  = id_kill;
    chk("id_fire", 32'(id_fire), 32'(e_fire));
    chk("id_stall", 32'(id_stall), 32'(e_stall));
    chk("id_kill", 32'(id_kill), 32'(e_kill));
    @(posedge clk);
    commit();
    #1;
    chk_state("cyc");
  endtask

  // Called 1 time unit after a rising edge; reset is asserted and released between edges
  task automatic async_reset();
    #1 rst = 1'b0;
    #1;
    m_busy = '0; m_inf = 0; m_err = 1'b0;
    predict();
    chk_state("rst");
    chk("rst_fire", 32'(id_fire), 32'(e_fire));
    chk("rst_stall", 32'(id_stall), 32'(e_stall));
    #1 rst = 1'b1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1_ren = 0; id_rs2_ren = 0; id_rd_wen = 0; id_serialize = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; is_ready = 1; redirect = 0;
    wb_valid = 0; wb_rd_wen = 0; wb_rd = 0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic r1, input logic [4:0] rs2,
                       input logic r2, input logic [4:0] rd, input logic ser);
    id_valid = 1; id_rs1 = rs1; id_rs1_ren = r1; id_rs2 = rs2; id_rs2_ren = r2;
    id_rd = rd; id_rd_wen = (rd != 5'd0); id_serialize = ser;
  endtask

  task automatic retire(input logic v, input logic wen, input logic [4:0] rd);
    wb_valid = v; wb_rd_wen = wen; wb_rd = rd;
  endtask

  initial begin
    idle();
    m_busy = '0; m_inf = 0; m_err = 1'b0;
    #12;
    predict();
    chk_state("por");
    chk("por_fire", 32'(id_fire), 32'd0);
    #2 rst = 1'b1;
    @(posedge clk); #1;

    // First issue: x6 becomes pending
    issue(5'd5, 1, 5'd0, 0, 5'd6, 0);
    cycle();
    chk("t1_fire", 32'(last_fire), 32'd1);
    chk("t1_busy", busy_map, 32'h40);
    chk("t1_inf", 32'(inflight), 32'd1);

    // Dependent consumer on x6 waits for the producer to retire
    issue(5'd0, 0, 5'd6, 1, 5'd7, 0);
    cycle();
    chk("t2_stall_a", 32'(last_stall), 32'd1);
    cycle();
    chk("t2_stall_b", 32'(last_stall), 32'd1);
    retire(1, 1, 5'd6);
    cycle();
`ifdef SCB_BYPASS_EN
    chk("t2_fire_retire", 32'(last_fire), 32'd1);
    idle();
`else
    chk("t2_fire_retire", 32'(last_fire), 32'd0);
    retire(0, 0, 5'd0);
    cycle();
    chk("t2_fire_after", 32'(last_fire), 32'd1);
    idle();
`endif
    chk("t2_busy", busy_map, 32'h80);
    retire(1, 1, 5'd7);
    cycle();
    idle();

    // Full pipeline: third independent instruction waits for a retire
    issue(5'd1, 1, 5'd2, 1, 5'd10, 0); cycle();
    issue(5'd1, 1, 5'd2, 1, 5'd11, 0); cycle();
    issue(5'd1, 1, 5'd2, 1, 5'd12, 0); cycle();
    chk("t3_full_stall", 32'(last_stall), 32'd1);
    chk("t3_full_inf", 32'(inflight), 32'd2);
    retire(1, 1, 5'd10); cycle();
    retire(0, 0, 5'd0);  cycle();
    chk("t3_fire", 32'(last_fire), 32'd1);
    chk("t3_inf", 32'(inflight), 32'd2);
    idle();
    retire(1, 1, 5'd11); cycle();
    retire(1, 1, 5'd12); cycle();
    idle();

    // Redirect kills the ID instruction without touching state
    issue(5'd1, 1, 5'd0, 0, 5'd3, 0);
    redirect = 1;
    cycle();
    chk("t4_kill", 32'(last_kill), 32'd1);
    chk("t4_nofire", 32'(last_fire), 32'd0);
    chk("t4_busy", busy_map, 32'h0);
    chk("t4_inf", 32'(inflight), 32'd0);
    idle();

    // Serializing instruction drains the pipe first
    issue(5'd0, 0, 5'd0, 0, 5'd20, 0); cycle();
    issue(5'd0, 0, 5'd0, 0, 5'd21, 0); cycle();
    issue(5'd0, 0, 5'd0, 0, 5'd22, 1);
    cycle();
    chk("t5_ser_stall", 32'(last_stall), 32'd1);
    retire(1, 1, 5'd20); cycle();
    retire(1, 1, 5'd21); cycle();
    retire(0, 0, 5'd0);
    for (int i = 0; i < 3 && !last_fire; i++) cycle();
    chk("t5_ser_fired", 32'(last_fire), 32'd1);
    idle();
    retire(1, 1, 5'd22); cycle();
    retire(1, 0, 5'd0); cycle();
    chk("t5_err", 32'(scb_err), 32'd1);
    chk("t5_inf0", 32'(inflight), 32'd0);
    idle();

    // Reset while a dependent instruction stalls on x5/x6
    issue(5'd0, 0, 5'd0, 0, 5'd5, 0); cycle();
    issue(5'd0, 0, 5'd0, 0, 5'd6, 0); cycle();
    chk("t6_busy", busy_map, 32'h60);
    issue(5'd5, 1, 5'd0, 0, 5'd8, 0); cycle();
    chk("t6_stall", 32'(last_stall), 32'd1);
    async_reset();
    chk("t6_rst_busy", busy_map, 32'h0);
    cycle();
    chk("t6_fire", 32'(last_fire), 32'd1);
    idle();

    // Random traffic, mostly protocol-legal retires
    for (int n = 0; n < 600; n++) begin
      issue(5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 9) == 0));
      id_valid = ($urandom_range(0, 9) < 8);
      is_ready = ($urandom_range(0, 9) < 8);
      redirect = ($urandom_range(0, 9) == 0);
      retire(0, 0, 5'd0);
      if ($urandom_range(0, 49) == 0) begin
        retire(1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      end else if (m_inf > 0 && $urandom_range(0, 9) < 4) begin
        if (m_busy != 32'h0 && $urandom_range(0, 4) != 0) begin
          int r;
          r = $urandom_range(1, 31);
          while (!m_busy[r]) r = (r % 31) + 1;
          retire(1, 1, 5'(r));
        end else begin
          retire(1, 0, 5'd0);
        end
      end
      cycle();
      if ($urandom_range(0, 79) == 0) async_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/scoreboard_ctrl.md
# scoreboard_ctrl

Issue controller for the three-stage ID→IS→WB integer pipeline. Tracks in-flight register writes with a 32-entry busy bitmap and an in-flight instruction counter. Decides each cycle whether the instruction held in ID may issue into IS, stalling on RAW/WAW hazards, on a full pipeline, and on serializing instructions (ebreak/fence/CSR). Sits between the `id` decode stage and the `stallable_pipeline` registers, and replaces the ad-hoc hazard gating done on stage-valid flags.

## Interface
Parameters:
- MAX_INFLIGHT, 2, maximum instructions issued but not yet retired (IS + WB); legal range 1–7.
- CNT_W, 3, width of the in-flight counter; must hold MAX_INFLIGHT.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted at 0).
- id_valid  in  1  ID holds a decoded instruction.
- id_rs1_ren / id_rs2_ren  in  1  source operand is read.
- id_rs1 / id_rs2  in  5  source register index.
- id_rd_wen  in  1  instruction writes rd.
- id_rd  in  5  destination index.
- id_serialize  in  1  instruction must issue into an empty pipeline.
- is_ready  in  1  IS stage can accept this cycle.
- redirect  in  1  control hazard resolved in IS; the ID instruction is wrong-path.
- wb_valid  in  1  an instruction retires this cycle.
- wb_rd_wen  in  1  the retiring instruction writes the regfile.
- wb_rd  in  5  retiring destination index.
- id_fire  out  1  issue accepted; the ID→IS register loads.
- id_stall  out  1  id_valid held back by a hazard (excludes redirect kills).
- id_kill  out  1  id_valid & redirect; the ID instruction is dropped.
- busy_map  out  32  registered pending-write bitmap; bit 0 is always 0.
- inflight  out  CNT_W  registered in-flight count.
- scb_err  out  1  sticky protocol error.

## Operation
- Hazards, evaluated from registered state plus the current inputs:
  - raw = (rs1_ren & busy[rs1]) | (rs2_ren & busy[rs2]).
  - waw = rd_wen & busy[rd].
  - full = inflight == MAX_INFLIGHT.
  - ser = id_serialize & (inflight != 0).
- Index 0 never counts as busy.
- id_stall = id_valid & ~redirect & (raw | waw | full | ser | ~is_ready).
- id_fire = id_valid & ~redirect & ~id_stall.
- On id_fire with rd_wen & rd≠0, set busy[rd].
- On wb_valid & wb_rd_wen & wb_rd≠0, clear busy[wb_rd].
- inflight next value = inflight + id_fire − wb_valid. Simultaneous fire and retire leaves it unchanged.
- Simultaneous set and clear of the same index: set wins (the new write is younger).
- Killed instructions never touch state.
- scb_err sets, and stays set until reset, on any of:
  - wb_valid while inflight == 0. The counter holds at 0.
  - wb_rd_wen to a non-busy nonzero index.
  - id_fire while full (unreachable unless the logic is broken).

## Timing
- Reset (rst=0, async): busy_map=0, inflight=0, scb_err=0. id_fire, id_stall, id_kill are then 0 whenever id_valid=0.
- id_fire, id_stall, id_kill are combinational, with the same-cycle decision. State updates on the next rising edge.
- Back-to-back dependent instructions: the consumer stalls from the cycle after the producer fires until the producer's wb_valid cycle (bypass build) or the following cycle (non-bypass build).
- Reset asserted mid-stall clears all state immediately. The first cycle after release treats every register as free.

## Configuration
- SCB_BYPASS_EN defined:
  - The raw and waw terms ignore an index being cleared by WB in the same cycle.
  - Requires a write-through regfile.
  - The dependent instruction fires in the retire cycle.
  - ser also ignores a single instruction retiring this cycle.
- Undefined:
  - Hazards use the registered busy_map only.
  - One extra stall cycle per dependency.

## Structure
- Shared package cpu_pkg:
  - REG_IDX_W=5.
  - NUM_REGS=32.
  - MAX_INFLIGHT default.
  - scb_err cause encoding (UNDERFLOW, SPURIOUS_CLR, OVERFLOW).
- One sub-module, scb_hazard_chk: purely combinational raw/waw lookup, instantiated once, with the bypass mux inside it.

## Test plan
- Reset, then id_valid with rs1=5, rd=6, is_ready=1 → id_fire=1; next cycle busy_map=0x40, inflight=1.
- Producer rd=6 fires, consumer reads rs2=6 → id_stall=1 until wb_rd=6 retires. With SCB_BYPASS_EN, fire in the same cycle as retirement; without it, fire one cycle later.
- MAX_INFLIGHT=2, three independent instructions with no retire → the third stalls with full. A wb_valid pulse lets it fire; inflight stays 2.
- redirect=1 with id_valid=1 → id_kill=1, id_fire=0, busy_map and inflight unchanged.
- id_serialize with inflight=2 → stalls until both retire, fires at inflight=0. A spurious wb_valid at inflight=0 sets scb_err=1 and leaves inflight=0.
- Drive rst low mid-stall with busy_map=0x60 → outputs clear asynchronously. After release, a dependent instruction on x5 fires immediately.
